// File: rtl/fetch_word_supplier.sv
// Instruction word supplier: a small queue of sequential words in front of a read bus.
// Define IMEM_PREFETCH_EN to enable sequential prefetch and the advance path.
module fetch_word_supplier #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] req_pc,
  input  logic        req_valid,
  input  logic        flush,
  output logic [31:0] inst,
  output logic        inst_arrived,
  output logic [31:0] bus_addr,
  output logic        bus_ren,
  input  logic        bus_busy,
  input  logic [31:0] bus_rdata
);

`ifdef IMEM_PREFETCH_EN
  localparam int QD = DEPTH;
  localparam int AD = (QD < 2) ? 2 : QD;
`else
  localparam int QD = 1;
  localparam int AD = 1;
`endif
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_e;

  state_e          state_q;
  logic [29:0]     rd_tag_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [29:0]     tag_q  [AD];
  logic [29:0]     tag_d  [AD];
  logic [31:0]     data_q [AD];
  logic [31:0]     data_d [AD];

  logic [29:0] req_tag, wr_tag, pf_tag;
  logic        req_live, hit_head, hit_next, in_flight, miss, advance;
  logic        pf_ok, complete, keep, bypass;
  logic        unused_pc_bits;

  assign unused_pc_bits = ^req_pc[1:0];
  assign req_tag   = req_pc[31:2];
  assign req_live  = req_valid && !flush;
  assign hit_head  = (cnt_q != '0) && (tag_q[0] == req_tag);
  // A request for the word already on the bus waits for it instead of missing.
  assign in_flight = (state_q == S_READ) && (rd_tag_q == req_tag);

`ifdef IMEM_PREFETCH_EN
  logic [29:0] tail_tag;
  always_comb begin
    tail_tag = tag_q[0];
    for (int i = 1; i < AD; i++)
      if (cnt_q == CW'(i + 1)) tail_tag = tag_q[i];
  end
  assign hit_next = (cnt_q > CW'(1)) && (tag_q[1] == req_tag);
  assign pf_ok    = (cnt_q != '0) && (cnt_q < CW'(QD)) && !flush && (tail_tag != '1);
  assign pf_tag   = tail_tag + 30'd1;
`else
  assign hit_next = 1'b0;
  assign pf_ok    = 1'b0;
  assign pf_tag   = '0;
`endif

  assign miss    = req_live && !hit_head && !hit_next && !in_flight;
  assign advance = req_live && !hit_head && hit_next;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    bus_ren  = 1'b0;
    bus_addr = 32'd0;
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (miss) begin
            bus_ren  = 1'b1;
            bus_addr = {req_tag, 2'b00};
          end else if (pf_ok) begin
            bus_ren  = 1'b1;
            bus_addr = {pf_tag, 2'b00};
          end
        end
        default: begin
          bus_ren  = 1'b1;
          bus_addr = {rd_tag_q, 2'b00};
        end
      endcase
    end
  end

  assign complete = bus_ren && !bus_busy;
  assign wr_tag   = bus_addr[31:2];
  // Data from a drained or superseded read is never written or forwarded.
  assign keep     = complete && !flush &&
                    ((state_q == S_IDLE) || ((state_q == S_READ) && !miss));
  assign bypass   = keep && (wr_tag == req_tag);

  assign inst_arrived = !rst && req_live && (hit_head || bypass);
  assign inst = !inst_arrived ? 32'd0 : (hit_head ? data_q[0] : bus_rdata);

  always_comb begin
    cnt_d  = cnt_q;
    tag_d  = tag_q;
    data_d = data_q;
    if (flush || miss) begin
      cnt_d = '0;
    end else if (advance) begin
      for (int i = 0; i < AD - 1; i++) begin
        tag_d[i]  = tag_q[i + 1];
        data_d[i] = data_q[i + 1];
      end
      cnt_d = cnt_q - CW'(1);
    end
    if (keep) begin
      for (int i = 0; i < AD; i++) begin
        if (cnt_d == CW'(i)) begin
          tag_d[i]  = wr_tag;
          data_d[i] = bus_rdata;
        end
      end
      cnt_d = cnt_d + CW'(1);
    end
  end

  // NOTE: queue storage is not reset; cnt_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rd_tag_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus_ren && bus_busy) begin
            state_q  <= S_READ;
            rd_tag_q <= bus_addr[31:2];
          end
        end
        S_READ: begin
          if (flush) begin
            state_q <= complete ? S_IDLE : S_DRAIN;
          end else if (miss) begin
            if (complete) rd_tag_q <= req_tag;
            else          state_q  <= S_DRAIN;
          end else if (complete) begin
            state_q <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (complete) begin
            if (miss) begin
              state_q  <= S_READ;
              rd_tag_q <= req_tag;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
